// File: rtl/gen_grf_sb_if.sv
// rtl/gen_grf_sb_if.sv - read/issue/writeback bundle of the scoreboarded register file
// master drives addresses, issue and writeback; slave is the register file.
interface gen_grf_sb_if #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int NR = 2
);
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic [NR-1:0]    rbusy;
   logic             iss_en;
   logic [AW-1:0]    iss_addr;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [DW-1:0]    wdata;
   logic [31:0]      wpc;
   logic [AW:0]      busy_cnt;

   modport master (
      output raddr, iss_en, iss_addr, we, waddr, wdata, wpc,
      input  rdata, rbusy, busy_cnt
   );

   modport slave (
      input  raddr, iss_en, iss_addr, we, waddr, wdata, wpc,
      output rdata, rbusy, busy_cnt
   );
endinterface

// File: rtl/gen_grf_sb.sv
// rtl/gen_grf_sb.sv - NR-read register file with write-through bypass and pending-write scoreboard
// Optional GRF_TRACE_EN prints one trace line per accepted write.
module gen_grf_sb #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int NR = 2
) (
   input logic          clk,
   input logic          reset,
   gen_grf_sb_if.slave  bus
);
   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] CNT_ONE = 1;

   logic [DW-1:0]    regs [DEPTH];
   logic [DEPTH-1:0] pending;
   logic [DEPTH-1:0] pending_nxt;
   logic [AW:0]      cnt;
   logic [NR*DW-1:0] rdata_c;
   logic [NR-1:0]    rbusy_c;
   logic             wr_ok;
   logic             set_v;
   logic             set_new;
   logic             clr_eff;

   always_comb begin
      logic [AW-1:0] ra;
      logic          hit;
      rdata_c = '0;
      rbusy_c = '0;
      ra      = '0;
      hit     = 1'b0;
      for (int k = 0; k < NR; k++) begin
         ra  = bus.raddr[k*AW +: AW];
         hit = bus.we && (bus.waddr == ra);
         if (ra != '0) begin
            rdata_c[k*DW +: DW] = hit ? bus.wdata : regs[ra];
            rbusy_c[k]          = pending[ra] && !hit;
         end
      end
   end

   assign bus.rdata    = rdata_c;
   assign bus.rbusy    = rbusy_c;
   assign bus.busy_cnt = cnt;

   // A writeback that lands on the register being re-issued leaves it pending:
   // the younger producer still owes a value.
   always_comb begin
      wr_ok       = bus.we && (bus.waddr != '0);
      set_v       = bus.iss_en && (bus.iss_addr != '0);
      set_new     = set_v && !pending[bus.iss_addr];
      clr_eff     = wr_ok && pending[bus.waddr] &&
                    !(set_v && (bus.iss_addr == bus.waddr));
      pending_nxt = pending;
      if (clr_eff) pending_nxt[bus.waddr] = 1'b0;
      if (set_v)   pending_nxt[bus.iss_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         pending <= '0;
         cnt     <= '0;
      end else begin
         if (wr_ok) regs[bus.waddr] <= bus.wdata;
         pending <= pending_nxt;
         case ({set_new, clr_eff})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef GRF_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && wr_ok)
         $display("%d@%h: $%d <= %h", $time, bus.wpc, bus.waddr, bus.wdata);
   end
`else
   logic unused_wpc;
   assign unused_wpc = ^bus.wpc;
`endif

endmodule
